sram_rd_responder: RTL and testbench

SRAM_RD_RESPONDER -- requirements
Module: sram_rd_responder

---
 rtl/sram_rd_responder.sv | 136 +++++++++++++
 tb/tb_sram_rd_responder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_responder.sv
// AXI-style read-only responder in front of a single-port SRAM with one-cycle read latency.
// Optional decode-error response for out-of-region addresses: define SRAM_RD_DECERR_EN.
module sram_rd_responder #(
  parameter int          MEM_AW  = 14,
  parameter logic [15:0] BASE_HI = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [7:0]        RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  // state | meaning
  // IDLE  | waiting for an address; ARREADY_S high
  // REQ   | SRAM read strobe for the current word
  // LOAD  | SRAM data returns, captured into rdata_q
  // RESP  | beat presented on R channel until RREADY_S
  typedef enum logic [1:0] {IDLE, REQ, LOAD, RESP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]        burst_q, burst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              decerr_q, decerr_d;
  logic              last_beat;

  // ARSIZE_S is ignored and only part of ARADDR_S is decoded.
  logic unused_inputs;
  assign unused_inputs = ^{ARSIZE_S, ARADDR_S, BASE_HI};

  assign last_beat = (beat_cnt_q == len_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      burst_q    <= '0;
      rdata_q    <= '0;
      decerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      burst_q    <= burst_d;
      rdata_q    <= rdata_d;
      decerr_q   <= decerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    burst_d    = burst_q;
    rdata_d    = rdata_q;
    decerr_d   = decerr_q;
    unique case (state_q)
      IDLE: begin
        if (ARVALID_S) begin
          id_d       = ARID_S;
          addr_d     = ARADDR_S[MEM_AW+1:2];
          len_d      = ARLEN_S;
          burst_d    = ARBURST_S;
          beat_cnt_d = '0;
`ifdef SRAM_RD_DECERR_EN
          decerr_d   = (ARADDR_S[31:16] != BASE_HI);
`else
          decerr_d   = 1'b0;
`endif
          state_d    = REQ;
        end
      end
      REQ: state_d = LOAD;
      LOAD: begin
        rdata_d = decerr_q ? 32'h0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (RREADY_S) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            // FIXED bursts re-read the same word; INCR and WRAP step and roll over.
            if (burst_q != 2'b00) addr_d = addr_q + MEM_AW'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ARREADY_S = rst && (state_q == IDLE);
    mem_en    = (state_q == REQ) && !decerr_q;
    mem_addr  = addr_q;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    RDATA_S   = '0;
    RID_S     = '0;
    RRESP_S   = 2'b00;
    if (state_q == RESP) begin
      RVALID_S = 1'b1;
      RLAST_S  = last_beat;
      RDATA_S  = rdata_q;
      RID_S    = id_q;
      RRESP_S  = decerr_q ? 2'b11 : 2'b00;
    end
  end

endmodule

// File: tb/tb_sram_rd_responder.sv
// Directed bench for sram_rd_responder with a one-cycle-latency SRAM model.
module tb_sram_rd_responder;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    ARID_S;
  logic [31:0]   ARADDR_S;
  logic [3:0]    ARLEN_S;
  logic [2:0]    ARSIZE_S;
  logic [1:0]    ARBURST_S;
  logic          ARVALID_S;
  logic          ARREADY_S;
  logic [7:0]    RID_S;
  logic [31:0]   RDATA_S;
  logic [1:0]    RRESP_S;
  logic          RLAST_S;
  logic          RVALID_S;
  logic          RREADY_S;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  logic [31:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  sram_rd_responder #(.MEM_AW(AW), .BASE_HI(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an address for one cycle; returns just after the accepting edge.
  task automatic ar_issue(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    chk("arready_before_ar", {31'b0, ARREADY_S}, 32'd1);
    ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARBURST_S = burst;
    ARSIZE_S = 3'd2; ARVALID_S = 1'b1;
    tick();
    ARVALID_S = 1'b0;
  endtask

  // Entered in REQ; checks REQ, LOAD, RESP and handshakes with RREADY_S already high.
  task automatic beat(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic last, input logic [7:0] id, input logic en_exp,
                      input logic [1:0] resp);
    chk({tag, "_req_en"},    {31'b0, mem_en}, {31'b0, en_exp});
    if (en_exp) chk({tag, "_req_addr"}, {18'b0, mem_addr}, {18'b0, a});
    chk({tag, "_req_rvalid"}, {31'b0, RVALID_S}, 32'd0);
    chk({tag, "_req_arready"}, {31'b0, ARREADY_S}, 32'd0);
    tick();
    chk({tag, "_load_en"},   {31'b0, mem_en}, 32'd0);
    chk({tag, "_load_rvalid"}, {31'b0, RVALID_S}, 32'd0);
    tick();
    chk({tag, "_rvalid"}, {31'b0, RVALID_S}, 32'd1);
    chk({tag, "_rdata"},  RDATA_S, d);
    chk({tag, "_rlast"},  {31'b0, RLAST_S}, {31'b0, last});
    chk({tag, "_rid"},    {24'b0, RID_S}, {24'b0, id});
    chk({tag, "_rresp"},  {30'b0, RRESP_S}, {30'b0, resp});
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_0000; mem[1] = 32'h2222_0001; mem[2] = 32'h3333_0002;
    mem[3] = 32'h4444_0003; mem[4] = 32'hDEAD_BEEF; mem[(1<<AW)-1] = 32'hCAFE_3FFF;
    mem_rdata = 32'h0;
    rst = 1'b0; ARID_S = 8'h0; ARADDR_S = 32'h0; ARLEN_S = 4'h0; ARSIZE_S = 3'h0;
    ARBURST_S = 2'b01; ARVALID_S = 1'b0; RREADY_S = 1'b0;

    tick(); tick();
    chk("rst_arready", {31'b0, ARREADY_S}, 32'd0);
    chk("rst_rvalid",  {31'b0, RVALID_S}, 32'd0);
    chk("rst_rdata",   RDATA_S, 32'd0);
    chk("rst_mem_en",  {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_arready", {31'b0, ARREADY_S}, 32'd1);

    // Single read of word 4
    RREADY_S = 1'b1;
    ar_issue(8'h12, 32'h0000_0010, 4'd0, 2'b01);
    beat("single", 14'd4, 32'hDEAD_BEEF, 1'b1, 8'h12, 1'b1, 2'b00);
    chk("single_arready_after", {31'b0, ARREADY_S}, 32'd1);
    chk("single_rvalid_after",  {31'b0, RVALID_S}, 32'd0);
    chk("single_rdata_after",   RDATA_S, 32'd0);

    // INCR burst of four from word 0
    ar_issue(8'h34, 32'h0, 4'd3, 2'b01);
    beat("incr0", 14'd0, 32'h1111_0000, 1'b0, 8'h34, 1'b1, 2'b00);
    beat("incr1", 14'd1, 32'h2222_0001, 1'b0, 8'h34, 1'b1, 2'b00);
    beat("incr2", 14'd2, 32'h3333_0002, 1'b0, 8'h34, 1'b1, 2'b00);
    beat("incr3", 14'd3, 32'h4444_0003, 1'b1, 8'h34, 1'b1, 2'b00);

    // FIXED burst stays on word 2
    ar_issue(8'h56, 32'h8, 4'd2, 2'b00);
    beat("fixed0", 14'd2, 32'h3333_0002, 1'b0, 8'h56, 1'b1, 2'b00);
    beat("fixed1", 14'd2, 32'h3333_0002, 1'b0, 8'h56, 1'b1, 2'b00);
    beat("fixed2", 14'd2, 32'h3333_0002, 1'b1, 8'h56, 1'b1, 2'b00);

    // WRAP/INCR address rolls over at the top of the SRAM
    ar_issue(8'h9C, 32'h0000_FFFC, 4'd1, 2'b10);
    beat("roll0", 14'h3FFF, 32'hCAFE_3FFF, 1'b0, 8'h9C, 1'b1, 2'b00);
    beat("roll1", 14'h0000, 32'h1111_0000, 1'b1, 8'h9C, 1'b1, 2'b00);

    // Backpressure on beat 0, with a stray ARVALID that must be ignored
    RREADY_S = 1'b0;
    ar_issue(8'h78, 32'h4, 4'd1, 2'b01);
    ARVALID_S = 1'b1; ARADDR_S = 32'h10; ARID_S = 8'hEE;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid",  {31'b0, RVALID_S}, 32'd1);
      chk("bp_rdata",   RDATA_S, 32'h2222_0001);
      chk("bp_rlast",   {31'b0, RLAST_S}, 32'd0);
      chk("bp_mem_en",  {31'b0, mem_en}, 32'd0);
      chk("bp_arready", {31'b0, ARREADY_S}, 32'd0);
      tick();
    end
    chk("bp_rid_held", {24'b0, RID_S}, 32'h78);
    ARVALID_S = 1'b0;
    RREADY_S = 1'b1;
    tick();
    beat("bp1", 14'd2, 32'h3333_0002, 1'b1, 8'h78, 1'b1, 2'b00);
    chk("bp_no_queued_ar", {31'b0, ARREADY_S}, 32'd1);

    // Reset during the second beat of a four-beat burst
    ar_issue(8'h9A, 32'h0, 4'd3, 2'b01);
    beat("rb0", 14'd0, 32'h1111_0000, 1'b0, 8'h9A, 1'b1, 2'b00);
    tick(); tick();
    chk("rb1_rvalid", {31'b0, RVALID_S}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_async_rvalid",  {31'b0, RVALID_S}, 32'd0);
    chk("rb_async_arready", {31'b0, ARREADY_S}, 32'd0);
    chk("rb_async_addr",    {18'b0, mem_addr}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rb_arready", {31'b0, ARREADY_S}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("rb_no_rvalid", {31'b0, RVALID_S}, 32'd0);
      chk("rb_no_mem_en", {31'b0, mem_en}, 32'd0);
      tick();
    end

`ifdef SRAM_RD_DECERR_EN
    ar_issue(8'hBC, 32'h0001_0000, 4'd1, 2'b01);
    beat("dec0", 14'd0, 32'h0, 1'b0, 8'hBC, 1'b0, 2'b11);
    beat("dec1", 14'd1, 32'h0, 1'b1, 8'hBC, 1'b0, 2'b11);
    chk("dec_arready_after", {31'b0, ARREADY_S}, 32'd1);
`else
    // Upper address bits are don't-care in the default build
    ar_issue(8'hBC, 32'h0001_0010, 4'd0, 2'b01);
    beat("hi_ign", 14'd4, 32'hDEAD_BEEF, 1'b1, 8'hBC, 1'b1, 2'b00);
    chk("hi_ign_arready_after", {31'b0, ARREADY_S}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
